// File: rtl/hazard_pkg.sv
// Shared types and encodings for the hazard controller: FSM states, bypass-select
// encodings and the register index type.
package hazard_pkg;

    localparam int HZ_REG_AW      = 5;
    localparam int FWD_RF         = 0;
    localparam int FWD_STAGE_BASE = 1;
    localparam int FLUSH_CNT_W    = 3;

    typedef logic [HZ_REG_AW-1:0] reg_idx_t;

    typedef enum logic {
        HZ_IDLE  = 1'b0,
        HZ_FLUSH = 1'b1
    } hz_state_t;

endpackage

// File: rtl/reg_scoreboard.sv
// One pending bit per architectural register (x0 never tracked) for results
// still owed by variable-latency units.
module reg_scoreboard #(
    parameter int NUM_REGS = 32,
    parameter int REG_AW   = 5
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                set_en,
    input  logic [REG_AW-1:0]   set_rd,
    input  logic                clr_en,
    input  logic [REG_AW-1:0]   clr_rd,
    output logic [NUM_REGS-1:0] pending,
    output logic                busy
);

    logic [NUM_REGS-1:0] r_pending;

    assign r_pending[0] = 1'b0;

    genvar gi;
    generate
        for (gi = 1; gi < NUM_REGS; gi++) begin : g_bit
            logic w_set;
            logic w_clr;
            assign w_set = set_en && (set_rd == REG_AW'(gi));
            assign w_clr = clr_en && (clr_rd == REG_AW'(gi));

            // Set takes priority over a same-edge clear.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_pending[gi] <= 1'b0;
                end else if (w_set) begin
                    r_pending[gi] <= 1'b1;
                end else if (w_clr) begin
                    r_pending[gi] <= 1'b0;
                end
            end
        end
    endgenerate

    assign pending = r_pending;
    assign busy    = |r_pending;

    // The WAW stall should make a same-register set/clear collision impossible.
    a_no_set_clr_collision: assert property (@(posedge clk) disable iff (!rst_n)
        !(set_en && clr_en && (set_rd == clr_rd) && (set_rd != '0)));

endmodule

// File: rtl/hazard_ctrl.sv
// Decode-side stall / bypass / redirect-flush control with a long-latency scoreboard.
// Optional build macro HAZARD_PERF_EN adds saturating stall/flush cycle counters.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int NUM_REGS       = 32,
    parameter int REG_AW         = 5,
    parameter int FWD_STAGES     = 2,
    parameter int BRANCH_PENALTY = 2,
    localparam int FSW           = $clog2(FWD_STAGES + 1)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         dec_valid,
    input  logic [REG_AW-1:0]            dec_rs1,
    input  logic [REG_AW-1:0]            dec_rs2,
    input  logic                         dec_uses_rs1,
    input  logic                         dec_uses_rs2,
    input  logic [REG_AW-1:0]            dec_rd,
    input  logic                         dec_writes_rd,
    input  logic                         dec_is_long,
    input  logic [REG_AW-1:0]            ex_rd,
    input  logic                         ex_is_load,
    input  logic [FWD_STAGES*REG_AW-1:0] stage_rd,
    input  logic [FWD_STAGES-1:0]        stage_wr,
    input  logic                         long_done,
    input  logic [REG_AW-1:0]            long_done_rd,
    input  logic                         redirect,
    output logic                         stall,
    output logic                         issue,
    output logic                         flush_fetch,
    output logic                         flush_dec,
    output logic [FSW-1:0]               fwd_sel_rs1,
    output logic [FSW-1:0]               fwd_sel_rs2,
    output logic                         sb_busy,
    output logic [31:0]                  perf_stall_cnt,
    output logic [31:0]                  perf_flush_cnt
);

    localparam logic [FLUSH_CNT_W-1:0] FLUSH_LOAD =
        FLUSH_CNT_W'((BRANCH_PENALTY > 1) ? (BRANCH_PENALTY - 2) : 0);

    logic [NUM_REGS-1:0]    w_pending;
    logic                   w_sb_set;
    logic                   w_sb_clr;
    logic                   w_flush;
    logic                   w_raw_long;
    logic                   w_waw_long;
    logic                   w_load_use;
    logic                   w_struct;
    logic                   w_hazard;
    hz_state_t              r_state;
    logic [FLUSH_CNT_W-1:0] r_flush_cnt;

    assign w_sb_set = issue && dec_is_long && dec_writes_rd && (dec_rd != '0);
    assign w_sb_clr = long_done && (long_done_rd != '0);

    reg_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .REG_AW   (REG_AW)
    ) u_sb (
        .clk     (clk),
        .rst_n   (rst_n),
        .set_en  (w_sb_set),
        .set_rd  (dec_rd),
        .clr_en  (w_sb_clr),
        .clr_rd  (long_done_rd),
        .pending (w_pending),
        .busy    (sb_busy)
    );

    // x0 never has a pending bit, so no explicit x0 guard is needed on the RAW/WAW terms.
    assign w_raw_long = (dec_uses_rs1 && w_pending[dec_rs1]) ||
                        (dec_uses_rs2 && w_pending[dec_rs2]);
    assign w_waw_long = dec_writes_rd && w_pending[dec_rd];
    assign w_load_use = ex_is_load && (ex_rd != '0) &&
                        ((dec_uses_rs1 && (ex_rd == dec_rs1)) ||
                         (dec_uses_rs2 && (ex_rd == dec_rs2)));
    assign w_struct   = dec_is_long && sb_busy;
    assign w_hazard   = w_raw_long || w_waw_long || w_load_use || w_struct;

    assign w_flush     = redirect || (r_state == HZ_FLUSH);
    assign flush_fetch = w_flush;
    assign flush_dec   = w_flush;
    assign stall       = dec_valid && !w_flush && w_hazard;
    assign issue       = dec_valid && !stall && !w_flush;

    // Scanning from the far stage inward leaves the nearest match selected.
    always_comb begin
        fwd_sel_rs1 = FSW'(FWD_RF);
        fwd_sel_rs2 = FSW'(FWD_RF);
        for (int k = FWD_STAGES - 1; k >= 0; k--) begin
            if (stage_wr[k] && (dec_rs1 != '0) && (stage_rd[k*REG_AW +: REG_AW] == dec_rs1)) begin
                fwd_sel_rs1 = FSW'(k + FWD_STAGE_BASE);
            end
            if (stage_wr[k] && (dec_rs2 != '0) && (stage_rd[k*REG_AW +: REG_AW] == dec_rs2)) begin
                fwd_sel_rs2 = FSW'(k + FWD_STAGE_BASE);
            end
        end
    end

    // The redirect cycle itself is the first flush cycle, so FLUSH covers the remainder.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= HZ_IDLE;
            r_flush_cnt <= '0;
        end else if (redirect) begin
            r_state     <= (BRANCH_PENALTY > 1) ? HZ_FLUSH : HZ_IDLE;
            r_flush_cnt <= FLUSH_LOAD;
        end else if (r_state == HZ_FLUSH) begin
            if (r_flush_cnt == '0) begin
                r_state <= HZ_IDLE;
            end else begin
                r_flush_cnt <= r_flush_cnt - 1'b1;
            end
        end
    end

`ifdef HAZARD_PERF_EN
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cyc_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt     <= '0;
            r_flush_cyc_cnt <= '0;
        end else begin
            if (stall && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (flush_dec && (r_flush_cyc_cnt != '1)) begin
                r_flush_cyc_cnt <= r_flush_cyc_cnt + 32'd1;
            end
        end
    end

    assign perf_stall_cnt = r_stall_cnt;
    assign perf_flush_cnt = r_flush_cyc_cnt;
`else
    assign perf_stall_cnt = '0;
    assign perf_flush_cnt = '0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed-vector bench for hazard_ctrl (BRANCH_PENALTY=3, two forwarding stages).
module tb_hazard_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_valid;
    logic [4:0]  dec_rs1, dec_rs2, dec_rd, ex_rd, long_done_rd;
    logic        dec_uses_rs1, dec_uses_rs2, dec_writes_rd, dec_is_long;
    logic        ex_is_load, long_done, redirect;
    logic [9:0]  stage_rd;
    logic [1:0]  stage_wr;
    logic        stall, issue, flush_fetch, flush_dec, sb_busy;
    logic [1:0]  fwd_sel_rs1, fwd_sel_rs2;
    logic [31:0] perf_stall_cnt, perf_flush_cnt;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    hazard_ctrl #(
        .NUM_REGS       (32),
        .REG_AW         (5),
        .FWD_STAGES     (2),
        .BRANCH_PENALTY (3)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .dec_valid      (dec_valid),
        .dec_rs1        (dec_rs1),
        .dec_rs2        (dec_rs2),
        .dec_uses_rs1   (dec_uses_rs1),
        .dec_uses_rs2   (dec_uses_rs2),
        .dec_rd         (dec_rd),
        .dec_writes_rd  (dec_writes_rd),
        .dec_is_long    (dec_is_long),
        .ex_rd          (ex_rd),
        .ex_is_load     (ex_is_load),
        .stage_rd       (stage_rd),
        .stage_wr       (stage_wr),
        .long_done      (long_done),
        .long_done_rd   (long_done_rd),
        .redirect       (redirect),
        .stall          (stall),
        .issue          (issue),
        .flush_fetch    (flush_fetch),
        .flush_dec      (flush_dec),
        .fwd_sel_rs1    (fwd_sel_rs1),
        .fwd_sel_rs2    (fwd_sel_rs2),
        .sb_busy        (sb_busy),
        .perf_stall_cnt (perf_stall_cnt),
        .perf_flush_cnt (perf_flush_cnt)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic idle();
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_uses_rs1 = 0; dec_uses_rs2 = 0;
        dec_rd = 0; dec_writes_rd = 0; dec_is_long = 0; ex_rd = 0; ex_is_load = 0;
        stage_rd = '0; stage_wr = '0; long_done = 0; long_done_rd = 0; redirect = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic dec_op(input logic [4:0] rs1, input logic u1, input logic [4:0] rs2,
                          input logic u2, input logic [4:0] rd, input logic wr, input logic lng);
        dec_valid = 1; dec_rs1 = rs1; dec_uses_rs1 = u1; dec_rs2 = rs2; dec_uses_rs2 = u2;
        dec_rd = rd; dec_writes_rd = wr; dec_is_long = lng;
    endtask

    task automatic reset_pulse();
        idle();
        rst_n = 0;
        #1;
        @(negedge clk);
        rst_n = 1;
        tick();
    endtask

    initial begin
        // Reset state
        idle();
        rst_n = 0;
        #2;
        check_val("rst_stall", {31'd0, stall}, 0);
        check_val("rst_issue", {31'd0, issue}, 0);
        check_val("rst_flush", {30'd0, flush_fetch, flush_dec}, 0);
        check_val("rst_fwd", {28'd0, fwd_sel_rs1, fwd_sel_rs2}, 0);
        check_val("rst_sb_busy", {31'd0, sb_busy}, 0);
        check_val("rst_perf", perf_stall_cnt | perf_flush_cnt, 0);
        @(negedge clk);
        rst_n = 1;
        tick();

        // Long op to x5, then a consumer held until the cycle after long_done
        dec_op(0, 0, 0, 0, 5, 1, 1); #1;
        check_val("long_issue", {31'd0, issue}, 1);
        tick();
        dec_op(5, 1, 0, 0, 6, 1, 0); #1;
        check_val("raw_stall", {30'd0, stall, issue}, 2'b10);
        check_val("sb_busy_set", {31'd0, sb_busy}, 1);
        tick();
        dec_op(0, 0, 0, 0, 8, 1, 1); #1;
        check_val("struct_stall", {31'd0, stall}, 1);
        tick();
        dec_op(0, 0, 0, 0, 5, 1, 0); #1;
        check_val("waw_stall", {31'd0, stall}, 1);
        tick();
        dec_op(5, 1, 0, 0, 6, 1, 0);
        long_done = 1; long_done_rd = 5; #1;
        check_val("raw_done_cycle", {31'd0, stall}, 1);
        tick();
        long_done = 0; #1;
        check_val("raw_release", {30'd0, stall, issue}, 2'b01);
        check_val("sb_busy_clr", {31'd0, sb_busy}, 0);
        tick();

        // Long op writing x0 is not tracked
        dec_op(0, 0, 0, 0, 0, 1, 1); #1;
        check_val("long_x0_issue", {31'd0, issue}, 1);
        tick();
        idle(); #1;
        check_val("long_x0_untracked", {31'd0, sb_busy}, 0);

        // Load-use: one-cycle stall, then bypass from stage 0
        dec_op(0, 0, 7, 1, 1, 1, 0);
        ex_is_load = 1; ex_rd = 7; #1;
        check_val("load_use_stall", {30'd0, stall, issue}, 2'b10);
        tick();
        ex_is_load = 0; stage_rd = {5'd0, 5'd7}; stage_wr = 2'b01; #1;
        check_val("load_use_release", {30'd0, stall, issue}, 2'b01);
        check_val("load_use_fwd_rs2", {30'd0, fwd_sel_rs2}, 1);
        tick();
        idle();
        dec_op(0, 0, 0, 1, 1, 1, 0);
        ex_is_load = 1; ex_rd = 0; #1;
        check_val("load_x0_no_stall", {31'd0, stall}, 0);
        idle();

        // Forwarding priority and x0 exclusion
        dec_op(3, 1, 0, 0, 0, 0, 0);
        stage_rd = {5'd3, 5'd3}; stage_wr = 2'b11; #1;
        check_val("fwd_nearest", {30'd0, fwd_sel_rs1}, 1);
        stage_wr = 2'b10; #1;
        check_val("fwd_stage1", {30'd0, fwd_sel_rs1}, 2);
        stage_wr = 2'b00; #1;
        check_val("fwd_none", {30'd0, fwd_sel_rs1}, 0);
        stage_rd = '0; stage_wr = 2'b11; dec_rs1 = 0; #1;
        check_val("fwd_x0", {30'd0, fwd_sel_rs1}, 0);
        idle();
        tick();

        // Redirect: three flush cycles
        redirect = 1; #1;
        check_val("redir_c0", {30'd0, flush_fetch, flush_dec}, 2'b11);
        tick();
        redirect = 0; #1;
        check_val("redir_c1", {31'd0, flush_dec}, 1);
        tick();
        check_val("redir_c2", {31'd0, flush_dec}, 1);
        tick();
        check_val("redir_c3_done", {31'd0, flush_dec}, 0);

        // Second redirect one cycle later extends the flush
        redirect = 1; #1;
        check_val("redir2_c0", {31'd0, flush_dec}, 1);
        tick();
        check_val("redir2_c1", {31'd0, flush_dec}, 1);
        tick();
        redirect = 0; #1;
        check_val("redir2_c2", {31'd0, flush_dec}, 1);
        tick();
        check_val("redir2_c3", {31'd0, flush_dec}, 1);
        tick();
        check_val("redir2_c4_done", {31'd0, flush_dec}, 0);

        // Redirect overrides a load-use stall
        dec_op(0, 0, 7, 1, 1, 1, 0);
        ex_is_load = 1; ex_rd = 7; redirect = 1; #1;
        check_val("redir_over_stall", {29'd0, stall, issue, flush_dec}, 3'b001);
        tick();
        idle();
        tick();
        tick();
        check_val("redir_over_done", {31'd0, flush_dec}, 0);

        // Async reset with x9 pending and FSM in FLUSH
        dec_op(0, 0, 0, 0, 9, 1, 1); #1;
        check_val("x9_issue", {31'd0, issue}, 1);
        tick();
        idle();
        redirect = 1;
        tick();
        redirect = 0; #1;
        check_val("pre_rst_state", {30'd0, sb_busy, flush_dec}, 2'b11);
        rst_n = 0; #1;
        check_val("mid_rst_outputs", {26'd0, stall, issue, flush_fetch, flush_dec, sb_busy,
                                      |{fwd_sel_rs1, fwd_sel_rs2}}, 0);
        @(negedge clk);
        rst_n = 1;
        dec_op(9, 1, 0, 0, 10, 1, 0); #1;
        check_val("post_rst_x9", {30'd0, stall, issue}, 2'b01);
        idle();

        // Performance counters: 5 stall cycles then 2 flush edges
        reset_pulse();
        dec_op(0, 0, 7, 1, 1, 1, 0);
        ex_is_load = 1; ex_rd = 7;
        for (int i = 0; i < 5; i++) tick();
        idle(); #1;
`ifdef HAZARD_PERF_EN
        check_val("perf_stall", perf_stall_cnt, 5);
`else
        check_val("perf_stall_off", perf_stall_cnt, 0);
`endif
        redirect = 1;
        tick();
        redirect = 0;
        tick();
`ifdef HAZARD_PERF_EN
        check_val("perf_flush", perf_flush_cnt, 2);
        check_val("perf_stall_hold", perf_stall_cnt, 5);
`else
        check_val("perf_flush_off", perf_flush_cnt, 0);
`endif
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
